// File: rtl/bus_router_pkg.sv
// Shared types and default address map for the CPU data-bus router.
package bus_router_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR
    } state_t;

    typedef logic [3:0] dev_sel_t;

    localparam logic [31:0] DCACHE_BASE = 32'h0000_0000;
    localparam logic [31:0] DCACHE_MASK = 32'hFC00_0000;
    localparam logic [31:0] IRAM_BASE   = 32'hE000_0000;
    localparam logic [31:0] IRAM_MASK   = 32'hFFFF_0000;
    localparam logic [31:0] HWREGS_BASE = 32'hFFFF_0000;
    localparam logic [31:0] HWREGS_MASK = 32'hFFFF_0000;
    localparam logic [31:0] PATRAM_BASE = 32'hF000_0000;
    localparam logic [31:0] PATRAM_MASK = 32'hFFFF_0000;

    localparam logic [127:0] DEFAULT_DEV_BASE = {PATRAM_BASE, HWREGS_BASE, IRAM_BASE, DCACHE_BASE};
    localparam logic [127:0] DEFAULT_DEV_MASK = {PATRAM_MASK, HWREGS_MASK, IRAM_MASK, DCACHE_MASK};

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_router_if.sv
// CPU data port, per-device request/ack bundle and error-capture signals of the bus router.
interface bus_router_if #(
    parameter int unsigned NUM_DEV = 4
) ();
    import bus_router_pkg::*;

    logic                   cpud_request;
    logic [31:0]            cpud_addr;
    logic [31:0]            cpud_rdata;
    logic                   cpud_ack;
    logic                   cpud_error;
    logic [NUM_DEV-1:0]     dev_req;
    logic [NUM_DEV-1:0]     dev_ack;
    logic [NUM_DEV*32-1:0]  dev_rdata;
    logic                   err_clear;
    logic                   err_valid;
    logic [31:0]            err_addr;
    logic                   err_timeout;

    // Router side.
    modport slave (
        input  cpud_request, cpud_addr, dev_ack, dev_rdata, err_clear,
        output cpud_rdata, cpud_ack, cpud_error, dev_req, err_valid, err_addr, err_timeout
    );

    // CPU/device side.
    modport master (
        output cpud_request, cpud_addr, dev_ack, dev_rdata, err_clear,
        input  cpud_rdata, cpud_ack, cpud_error, dev_req, err_valid, err_addr, err_timeout
    );

endinterface

// File: rtl/bus_router_watchdog.sv
// Per-access watchdog counter: clear has priority, enable then adds one; expire flags the last allowed cycle.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = clear_i ? '0 : count_q;
        if (enable_i) begin
            count_d = count_d + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && !clear_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_router.sv
// CPU data-bus router: window decode, per-access watchdog, unmapped/timeout error acks.
// Optional sticky error capture enabled by defining BUS_ERR_CAPTURE_EN.
module bus_router
    import bus_router_pkg::*;
#(
    parameter int unsigned          NUM_DEV   = 4,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = DEFAULT_DEV_BASE,
    parameter logic [NUM_DEV*32-1:0] DEV_MASK = DEFAULT_DEV_MASK,
    parameter int unsigned          TIMEOUT   = 255,
    parameter logic [31:0]          ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    bus_router_if.slave  bus
);

    function automatic logic [31:0] mask_union();
        logic [31:0] m = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            m |= DEV_MASK[i*32 +: 32];
        end
        return m;
    endfunction

    localparam logic [31:0] ADDR_USED = mask_union();

    state_t   state_q;
    dev_sel_t sel_q;

    logic        hit;
    dev_sel_t    hit_idx;
    dev_sel_t    act_idx;
    logic        act_ack;
    logic [31:0] act_rdata;
    logic        accept;
    logic        ack_now;
    logic        expire;

    logic unused_addr_bits;
    assign unused_addr_bits = ^(bus.cpud_addr & ~ADDR_USED);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (!hit && ((bus.cpud_addr & DEV_MASK[i*32 +: 32]) == DEV_BASE[i*32 +: 32])) begin
                hit     = 1'b1;
                hit_idx = dev_sel_t'(i);
            end
        end
    end

    // The request cycle already listens to the decoded device so a same-cycle ack completes at once.
    assign act_idx = (state_q == IDLE) ? hit_idx : sel_q;

    always_comb begin
        act_ack   = 1'b0;
        act_rdata = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (act_idx == dev_sel_t'(i)) begin
                act_ack   = bus.dev_ack[i];
                act_rdata = bus.dev_rdata[i*32 +: 32];
            end
        end
    end

    assign accept  = (state_q == IDLE) && bus.cpud_request && hit;
    assign ack_now = (accept || (state_q == BUSY)) && act_ack;

    always_comb begin
        bus.dev_req = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            bus.dev_req[i] = accept && (hit_idx == dev_sel_t'(i));
        end
    end

    assign bus.cpud_ack   = ack_now || (state_q == ERR);
    assign bus.cpud_error = (state_q == ERR);
    assign bus.cpud_rdata = (state_q == ERR) ? ERR_RDATA : (ack_now ? act_rdata : '0);

    // Request cycle counts as the first elapsed cycle, so the error ack lands TIMEOUT cycles after the request.
    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i    (clock),
        .rst_i    (reset),
        .clear_i  (state_q != BUSY),
        .enable_i (accept || (state_q == BUSY)),
        .expire_o (expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpud_request) begin
                        sel_q <= hit_idx;
                        if (!hit) begin
                            state_q <= ERR;
                        end else if (!act_ack) begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (act_ack) begin
                        state_q <= IDLE;
                    end else if (expire) begin
                        state_q <= ERR;
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BUS_ERR_CAPTURE_EN
    logic [31:0] addr_q;
    logic        err_valid_q;
    logic [31:0] err_addr_q;
    logic        err_timeout_q;
    logic        err_set;

    assign err_set = ((state_q == IDLE) && bus.cpud_request && !hit)
                  || ((state_q == BUSY) && !act_ack && expire);

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q        <= '0;
            err_valid_q   <= 1'b0;
            err_addr_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && bus.cpud_request) begin
                addr_q <= bus.cpud_addr;
            end
            if (err_set && (!err_valid_q || bus.err_clear)) begin
                err_valid_q   <= 1'b1;
                err_addr_q    <= (state_q == BUSY) ? addr_q : bus.cpud_addr;
                err_timeout_q <= (state_q == BUSY);
            end else if (bus.err_clear) begin
                err_valid_q   <= 1'b0;
                err_addr_q    <= '0;
                err_timeout_q <= 1'b0;
            end
        end
    end

    assign bus.err_valid   = err_valid_q;
    assign bus.err_addr    = err_addr_q;
    assign bus.err_timeout = err_timeout_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = bus.err_clear;

    assign bus.err_valid   = 1'b0;
    assign bus.err_addr    = '0;
    assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_router.sv
// Randomized bench for bus_router against a transaction-level model of the address map and timing rules.
module tb_bus_router;

    localparam int unsigned NDEV = 4;
    localparam int          TMO  = 255;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic [31:0] win_base [NDEV] = '{32'h0000_0000, 32'hE000_0000, 32'hFFFF_0000, 32'hF000_0000};
    logic [31:0] win_mask [NDEV] = '{32'hFC00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_router_if #(.NUM_DEV(NDEV)) bus_if ();

    bus_router #(
        .NUM_DEV   (NDEV),
        .DEV_BASE  ({32'hF000_0000, 32'hFFFF_0000, 32'hE000_0000, 32'h0000_0000}),
        .DEV_MASK  ({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFC00_0000}),
        .TIMEOUT   (TMO),
        .ERR_RDATA (ERRD)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit          cap_en;
    bit          m_valid;
    logic [31:0] m_addr;
    bit          m_to;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < int'(NDEV); i++) begin
            if ((a & win_mask[i]) == win_base[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_addr  = '0;
        m_to    = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " dev_req"}, 64'(bus_if.dev_req), 64'(0));
        check({tag, " ack/err"}, 64'({bus_if.cpud_ack, bus_if.cpud_error}), 64'(0));
        check({tag, " rdata"}, 64'(bus_if.cpud_rdata), 64'(0));
    endtask

    task automatic check_err_regs(input string tag);
        check({tag, " errregs"}, 64'({bus_if.err_valid, bus_if.err_timeout, bus_if.err_addr}),
              64'({m_valid, m_to, m_addr}));
    endtask

    task automatic idle(input int n, input bit clr, input int late_dev);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus_if.cpud_request = 1'b0;
            bus_if.cpud_addr    = $urandom;
            bus_if.dev_rdata    = {$urandom, $urandom, $urandom, $urandom};
            bus_if.dev_ack      = 4'($urandom_range(0, 15));
            bus_if.err_clear    = clr && (k == 0);
            if (late_dev >= 0 && k == n - 1) bus_if.dev_ack[late_dev] = 1'b1;
            @(negedge clk);
            check_quiet($sformatf("idle%0d", k));
            if (cap_en && clr && k == 0) model_clear();
        end
    endtask

    // delay < 0: the device never acks; delay >= TMO: its ack arrives too late to count.
    task automatic run_txn(input logic [31:0] addr, input int delay, input logic [31:0] data,
                           input bit noise, input bit viol, input bit clr0);
        int   exp_dev;
        int   ack_cyc;
        bit   exp_err;
        logic [127:0] rd;
        logic [3:0]   ak;
        exp_dev = decode(addr);
        if (exp_dev < 0) begin
            ack_cyc = 1; exp_err = 1'b1;
        end else if (delay >= 0 && delay < TMO) begin
            ack_cyc = delay; exp_err = 1'b0;
        end else begin
            ack_cyc = TMO; exp_err = 1'b1;
        end
        for (int k = 0; k <= ack_cyc; k++) begin
            @(posedge clk); #1;
            bus_if.cpud_request = (k == 0) || (viol && $urandom_range(0, 3) == 0);
            bus_if.cpud_addr    = (k == 0) ? addr : $urandom;
            bus_if.err_clear    = clr0 && (k == 0);
            rd = {$urandom, $urandom, $urandom, $urandom};
            ak = noise ? 4'($urandom_range(0, 15)) : 4'd0;
            if (exp_dev >= 0) begin
                ak[exp_dev] = (k == delay);
                if (k == delay) rd[exp_dev*32 +: 32] = data;
            end
            bus_if.dev_ack   = ak;
            bus_if.dev_rdata = rd;
            @(negedge clk);
            check($sformatf("%h c%0d dev_req", addr, k), 64'(bus_if.dev_req),
                  64'((k == 0 && exp_dev >= 0) ? (4'b1 << exp_dev) : 4'b0));
            check($sformatf("%h c%0d ack/err", addr, k), 64'({bus_if.cpud_ack, bus_if.cpud_error}),
                  64'({k == ack_cyc, (k == ack_cyc) && exp_err}));
            check($sformatf("%h c%0d rdata", addr, k), 64'(bus_if.cpud_rdata),
                  64'((k != ack_cyc) ? 32'h0 : (exp_err ? ERRD : data)));
            if (cap_en && clr0 && k == 0) model_clear();
        end
        if (cap_en && exp_err && !m_valid) begin
            m_valid = 1'b1;
            m_addr  = addr;
            m_to    = (exp_dev >= 0);
        end
        bus_if.cpud_request = 1'b0;
        bus_if.err_clear    = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 5);
        if (r < int'(NDEV)) return win_base[r] | ($urandom & ~win_mask[r]);
        if (r == 4) return 32'h4000_0000 | ($urandom & 32'h3FFF_FFFF);
        return $urandom;
    endfunction

    initial begin
`ifdef BUS_ERR_CAPTURE_EN
        cap_en = 1'b1;
`else
        cap_en = 1'b0;
`endif
        model_clear();
        rst                 = 1'b1;
        bus_if.cpud_request = 1'b0;
        bus_if.cpud_addr    = '0;
        bus_if.dev_ack      = '0;
        bus_if.dev_rdata    = '0;
        bus_if.err_clear    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        check_err_regs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_txn(32'h0000_1234, 3, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        run_txn(32'hE000_0010, 0, 32'h2222_2222, 1'b1, 1'b0, 1'b0);
        run_txn(32'h8000_0000, 0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0, -1);
        check_err_regs("unmapped");

        run_txn(32'hF000_0004, -1, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(45, 1'b0, 3);
        check_err_regs("timeout");

        // Reset while BUSY on dev2; its later ack must be ignored.
        @(posedge clk); #1;
        bus_if.cpud_request = 1'b1;
        bus_if.cpud_addr    = 32'hFFFF_0004;
        bus_if.dev_ack      = '0;
        @(negedge clk);
        check("rstbusy dev_req", 64'(bus_if.dev_req), 64'(4'b0100));
        @(posedge clk); #1;
        bus_if.cpud_request = 1'b0;
        @(negedge clk);
        check_quiet("rstbusy wait");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst            = 1'b0;
        bus_if.dev_ack = 4'b0100;
        @(negedge clk);
        check_quiet("rstbusy lateack");
        model_clear();
        check_err_regs("rstbusy");
        run_txn(32'hFFFF_0000, 2, 32'h3333_3333, 1'b1, 1'b0, 1'b0);

        run_txn(32'h8000_0000, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        run_txn(32'h9000_0000, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, -1);
        check_err_regs("first kept");
        idle(2, 1'b1, -1);
        check_err_regs("cleared");
        run_txn(32'h9000_0040, 0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0, -1);
        check_err_regs("recapture");

        run_txn(32'hF000_0008, TMO - 1, 32'h4444_4444, 1'b1, 1'b0, 1'b0);
        run_txn(32'hE000_0100, TMO, 32'h5555_5555, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0, -1);
        check_err_regs("boundary");
        run_txn(32'h7000_0000, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0, -1);
        check_err_regs("set+clear");

        for (int t = 0; t < 60; t++) begin
            run_txn(rand_addr(), $urandom_range(0, 6), $urandom, 1'b1,
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0));
            idle($urandom_range(0, 2), ($urandom_range(0, 9) == 0), -1);
        end
        idle(1, 1'b0, -1);
        check_err_regs("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
